instr_encode_loader: RTL
========================

Name: instr_encode_loader

Overview:
Inverse of the instruction decoder. Accepts decoded instructions (instruction ID plus rs/rt/rd operands in the decoder's convention) over a valid/ready stream and encodes each into a 32-bit machine word. Writes encoded words sequentially into instruction memory through a registered write port. Used by the testbench/boot path to load programs before the processor FSM starts fetching.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, maximum words per load session (must be <= 2**ADDR_W)
BASE_ADDR, 0, word address of the first write in a session

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
start  in  1  1-cycle pulse; opens a load session
in_valid  in  1  instruction present
in_ready  out  1  encoder accepts this cycle
in_last  in  1  qualifies the final instruction of the session
in_id  in  32  instruction ID 1..29 (decoder numbering)
in_rs  in  32  argument 1 (register index, or 26-bit target for J type)
in_rt  in  32  argument 2 (register index, 16-bit immediate, or shamt)
in_rd  in  32  argument 3 / destination register index
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  write word address
mem_wdata  out  32  encoded instruction
busy  out  1  session active (state LOAD)
done  out  1  1-cycle pulse at session end
full  out  1  count == DEPTH
err  out  1  1-cycle pulse; accepted instruction rejected
count  out  ADDR_W+1  words written this session

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; count 0.
- States:
  - IDLE: start -> LOAD; count cleared to 0.
  - LOAD: accepts instructions. After the last write (handshake with in_last=1, or count reaching DEPTH) -> DONE.
  - DONE: one cycle; done=1; -> IDLE.
- start outside IDLE is ignored.
- in_ready = (state==LOAD) && !full && !pending_last. Transfer occurs when in_valid && in_ready.
- Latency: transfer at edge N -> mem_we=1 with mem_addr/mem_wdata valid for exactly the cycle after N. count increments at the same edge. mem_addr = BASE_ADDR + count (pre-increment); no wrap.
- Encoding (fields truncated: registers [4:0], immediate [15:0]):
  - R (ID 1-4): op 0, func = ID-1, rs[25:21], rt[20:16], rd[15:11], [10:6]=0.
  - R (ID 7, 8, 24): op 3, 4, 19; func 0; same field placement as ID 1-4.
  - I (ID 5, 6, 9, 10, 13-20, 25): op = ID-4 for 5-10, ID-5 for 13-20 and 25; rs[25:21], rd[20:16], rt[15:0].
  - Shift (ID 11, 12): op 7, rs[25:21], rd[20:16], [15:11]=0, rt[4:0] -> [10:6], func = ID-11.
  - J (ID 21-23): op 16-18, rs[25:0].
  - Syscall (ID 26-29): op 21, [25:6]=0, func = ID-26.
- Illegal ID (0 or >29): err=1 for the cycle after transfer; no mem_we; count unchanged. If in_last=1, the session still ends -> DONE.
- Full: when count reaches DEPTH, in_ready drops the same cycle; FSM -> DONE after the final write cycle.
- in_last accepted: in_ready=0 until DONE is reached.
- Reset mid-session: write in flight is dropped; everything returns to reset values.

Optional Feature:
ENC_RANGE_CHECK_EN:
- Defined:
  - Register operands must be <32.
  - Immediates (I type) must sign-fit 16 bits, i.e. in_rt[31:15] all equal.
  - Shamt must be <32.
  - J targets must be <2**26.
  - Any violation is handled as an illegal ID (err pulse, no write).
- Undefined: fields are silently truncated as above.

Test Plan:
- start; add (id 1, rs=1, rt=2, rd=3) -> next cycle mem_we=1, addr 0, wdata 0x00221800; count=1.
- addi (id 5, rs=1, rd=0, rt=100), then rt=0xFFFFFFFF -> wdata 0x04200064 at addr 0, then 0x0420FFFF at addr 1.
- srl (id 12, rs=1, rd=2, rt=3) -> 0x1C2200C1; j (id 21, rs=100, in_last=1) -> 0x40000064, then done pulse, busy=0.
- id 30 with in_valid -> err pulse, no mem_we, count unchanged; with ENC_RANGE_CHECK_EN, add with rd=40 -> err pulse.
- DEPTH=4, 6 valid adds back-to-back -> 4 writes at addr 0-3, full=1, in_ready=0, done pulse, 2 not accepted.
- reset=0 asserted the cycle after a transfer -> mem_we stays 0, count=0, state IDLE; start re-opens a session at BASE_ADDR.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Encodes decoded instructions (ID + rs/rt/rd) into 32-bit words and streams them into instruction memory.
// Latency: one cycle from accepted beat to mem_we/mem_addr/mem_wdata. Option: `ENC_RANGE_CHECK_EN rejects out-of-range fields.
// Backpressure: in_ready low outside LOAD, once count hits DEPTH, or after in_last has been accepted.
module instr_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [31:0]       in_id,
    input  logic [31:0]       in_rs,
    input  logic [31:0]       in_rt,
    input  logic [31:0]       in_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t              state_q;
    logic [ADDR_W:0]     count_q;
    logic                we_q, err_q, done_q, last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic        full_w, xfer;
    logic [5:0]  id6;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic        rs_reg_ok, rt_reg_ok, rd_reg_ok, imm_ok, tgt_ok;

    assign id6 = in_id[5:0];

`ifdef ENC_RANGE_CHECK_EN
    assign rs_reg_ok = ~|in_rs[31:5];
    assign rt_reg_ok = ~|in_rt[31:5];
    assign rd_reg_ok = ~|in_rd[31:5];
    assign imm_ok    = (&in_rt[31:15]) | (~|in_rt[31:15]);
    assign tgt_ok    = ~|in_rs[31:26];
`else
    assign rs_reg_ok = 1'b1;
    assign rt_reg_ok = 1'b1;
    assign rd_reg_ok = 1'b1;
    assign imm_ok    = 1'b1;
    assign tgt_ok    = 1'b1;
    logic unused_hi_bits;
    assign unused_hi_bits = &{1'b0, in_rs[31:26], in_rt[31:16], in_rd[31:5]};
`endif

    // Opcode/func values follow the decoder's numbering so a decode of this word returns the same ID.
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        case (in_id)
            32'd1, 32'd2, 32'd3, 32'd4: begin
                enc_word = {6'd0, in_rs[4:0], in_rt[4:0], in_rd[4:0], 5'd0, id6 - 6'd1};
                enc_ok   = rs_reg_ok & rt_reg_ok & rd_reg_ok;
            end
            32'd7: begin
                enc_word = {6'd3, in_rs[4:0], in_rt[4:0], in_rd[4:0], 11'd0};
                enc_ok   = rs_reg_ok & rt_reg_ok & rd_reg_ok;
            end
            32'd8: begin
                enc_word = {6'd4, in_rs[4:0], in_rt[4:0], in_rd[4:0], 11'd0};
                enc_ok   = rs_reg_ok & rt_reg_ok & rd_reg_ok;
            end
            32'd24: begin
                enc_word = {6'd19, in_rs[4:0], in_rt[4:0], in_rd[4:0], 11'd0};
                enc_ok   = rs_reg_ok & rt_reg_ok & rd_reg_ok;
            end
            32'd5, 32'd6, 32'd9, 32'd10: begin
                enc_word = {id6 - 6'd4, in_rs[4:0], in_rd[4:0], in_rt[15:0]};
                enc_ok   = rs_reg_ok & rd_reg_ok & imm_ok;
            end
            32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd18, 32'd19, 32'd20, 32'd25: begin
                enc_word = {id6 - 6'd5, in_rs[4:0], in_rd[4:0], in_rt[15:0]};
                enc_ok   = rs_reg_ok & rd_reg_ok & imm_ok;
            end
            32'd11, 32'd12: begin
                enc_word = {6'd7, in_rs[4:0], in_rd[4:0], 5'd0, in_rt[4:0], id6 - 6'd11};
                enc_ok   = rs_reg_ok & rd_reg_ok & rt_reg_ok;
            end
            32'd21, 32'd22, 32'd23: begin
                enc_word = {id6 - 6'd5, in_rs[25:0]};
                enc_ok   = tgt_ok;
            end
            32'd26, 32'd27, 32'd28, 32'd29: begin
                enc_word = {6'd21, 20'd0, id6 - 6'd26};
            end
            default: enc_ok = 1'b0;
        endcase
    end

    assign full_w   = (count_q == DEPTH_C);
    assign in_ready = (state_q == S_LOAD) && !full_w && !last_q;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        count_q <= '0;
                        last_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        if (enc_ok) begin
                            we_q    <= 1'b1;
                            addr_q  <= BASE_A + count_q[ADDR_W-1:0];
                            wdata_q <= enc_word;
                            count_q <= count_q + CW'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (in_last) last_q <= 1'b1;
                    end
                    // in_ready is already low here, so the final write is the one now on the port.
                    if (last_q || full_w) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    last_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == S_LOAD);
    assign done      = done_q;
    assign full      = full_w;
    assign err       = err_q;
    assign count     = count_q;

endmodule
